fifo_stream_reader: RTL and testbench

Drain stage sitting directly downstream of the team's BRAM-backed FIFO. It issues single-cycle read requests to the FIFO, tracks the in-flight reads across the FIFO's fixed read latency, and lands the returned words in a small skid buffer. The buffer is presented to the next stage as a valid/ready stream. The block never over-reads the FIFO and never drops a returned word, regardless of downstream stalls.

---
 rtl/fifo_stream_reader.sv | 119 +++++++++++
 tb/tb_fifo_stream_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain stage: credit-limited reads, latency tracking, skid buffer, valid/ready output
module fifo_stream_reader #(
    parameter int DATA_WITH  = 16,
    parameter int RD_LATENCY = 2,
    parameter int FLAG_LAG   = 1,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_WITH-1:0] fifo_data_i,
    output logic                 fifo_read_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_WITH-1:0] m_data_o,
    output logic                 busy_o,
    output logic [31:0]          word_count_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough for occupancy + in-flight + pending read without overflow
    localparam int SUM_W = CNT_W + 2;

    logic                  fifo_read_q;
    logic                  fifo_read_d;
    logic                  rd_prev_q;
    logic [RD_LATENCY-1:0] inflight_q;
    logic [RD_LATENCY-1:0] inflight_d;
    logic [DATA_WITH-1:0]  mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      occ_q;
    logic [CNT_W-1:0]      occ_d;
    logic [31:0]           word_count_q;

    logic                  push;
    logic                  pop;
    logic                  lag_ok;
    logic [1:0]            recent_reads;
    logic [SUM_W-1:0]      inflight_cnt;
    logic [SUM_W-1:0]      committed;

    // A word lands in the buffer in the cycle its in-flight bit leaves the pipe
    assign push = inflight_q[RD_LATENCY-1];
    assign pop  = m_valid_o & m_ready_i;

    assign recent_reads = {rd_prev_q, fifo_read_q};

    // Count in-flight reads and decide whether a new read may be issued
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(inflight_q[i]);
        end
        // The empty flag is stale for FLAG_LAG cycles after a read, so wait them out
        lag_ok = 1'b1;
        for (int i = 0; i < FLAG_LAG; i++) begin
            if (recent_reads[i]) begin
                lag_ok = 1'b0;
            end
        end
        committed   = SUM_W'(occ_q) + inflight_cnt + SUM_W'(fifo_read_q);
        fifo_read_d = enable_i && !fifo_empty_i && lag_ok &&
                      (committed < SUM_W'(BUF_DEPTH));
    end

    // Next state of the latency shift register and buffer occupancy
    always_comb begin
        inflight_d    = '0;
        inflight_d[0] = fifo_read_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    // Registered read issue, in-flight pipe, circular buffer and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_read_q  <= 1'b0;
            rd_prev_q    <= 1'b0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            word_count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fifo_read_q <= fifo_read_d;
            rd_prev_q   <= fifo_read_q;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= fifo_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                word_count_q <= word_count_q + 32'd1;
            end
        end
    end

    assign fifo_read_o  = fifo_read_q;
    assign m_valid_o    = (occ_q != '0);
    assign m_data_o     = mem_q[rd_ptr_q];
    assign busy_o       = (inflight_q != '0) || (occ_q != '0);
    assign word_count_o = word_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_read;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;
    logic [31:0] word_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WITH (16),
        .RD_LATENCY(2),
        .FLAG_LAG  (1),
        .BUF_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_read_o (fifo_read),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .busy_o      (busy),
        .word_count_o(word_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc, reads, xfers, first_rd, last_rd, min_gap, max_out, stable_bad;
    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] pipe1;
    logic [15:0] exp_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance the FIFO model just after the edge
    task automatic step();
        logic rd_s;
        @(negedge clk);
        rd_s = fifo_read;
        if (rd_s) begin
            if (reads > 0 && (cyc - last_rd) < min_gap) min_gap = cyc - last_rd;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            reads++;
        end
        if (m_valid && m_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                check("extra_word", {16'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
                exp_word = exp_q.pop_front();
                check("m_data_order", {16'd0, m_data}, {16'd0, exp_word});
            end
        end
        if ((reads - xfers) > max_out) max_out = reads - xfers;
        @(posedge clk);
        #1;
        cyc++;
        fifo_data = pipe1;
        if (rd_s && !rst) begin
            if (fifo_q.size() == 0) begin
                check("no_overread", 32'd1, 32'd0);
                pipe1 = 16'hDEAD;
            end else begin
                pipe1 = fifo_q.pop_front();
            end
        end else begin
            pipe1 = 16'hDEAD;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 16'(i));
            exp_q.push_back(base + 16'(i));
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset(input int n, input logic [15:0] base, input logic en, input logic rdy);
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        pipe1 = 16'hDEAD;
        step();
        step();
        load(n, base);
        enable = en;
        m_ready = rdy;
        rst = 1'b0;
        cyc = 0; reads = 0; xfers = 0; first_rd = -1; last_rd = 0;
        min_gap = 1000; max_out = 0; stable_bad = 0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = 16'h0; pipe1 = 16'hDEAD;

        // Reset state
        do_reset(0, 16'h0, 1'b0, 1'b0);
        check("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);

        // Basic drain of 5 words
        do_reset(5, 16'h0001, 1'b1, 1'b1);
        repeat (40) step();
        check("basic_first_read_cycle", first_rd, 32'd1);
        check("basic_reads", reads, 32'd5);
        check("basic_min_gap_ge2", {31'd0, min_gap >= 2}, 32'd1);
        check("basic_xfers", xfers, 32'd5);
        check("basic_word_count", word_count, 32'd5);
        check("basic_busy", {31'd0, busy}, 32'd0);

        // Downstream stall then release
        do_reset(8, 16'h0100, 1'b1, 1'b0);
        repeat (20) begin
            step();
            if (m_valid && m_data !== 16'h0100) stable_bad++;
        end
        check("stall_reads", reads, 32'd4);
        check("stall_outstanding", max_out, 32'd4);
        check("stall_m_valid", {31'd0, m_valid}, 32'd1);
        check("stall_m_data_head", {16'd0, m_data}, 32'h0100);
        check("stall_data_stable", stable_bad, 32'd0);
        m_ready = 1'b1;
        repeat (40) step();
        check("stall_word_count", word_count, 32'd8);
        check("stall_all_out", exp_q.size(), 32'd0);
        check("stall_max_outstanding", {31'd0, max_out <= 4}, 32'd1);
        check("stall_busy", {31'd0, busy}, 32'd0);

        // Empty flag lag: a single word
        do_reset(1, 16'h0AAA, 1'b1, 1'b1);
        repeat (20) step();
        check("lag_reads", reads, 32'd1);
        check("lag_xfers", xfers, 32'd1);
        check("lag_word_count", word_count, 32'd1);

        // Reset mid-operation
        do_reset(8, 16'h0200, 1'b1, 1'b0);
        for (int i = 0; i < 30 && reads < 3; i++) step();
        check("midrst_reached_3_reads", reads, 32'd3);
        rst = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        step();
        rst = 1'b0;
        check("midrst_fifo_read", {31'd0, fifo_read}, 32'd0);
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_word_count", word_count, 32'd0);
        m_ready = 1'b1;
        xfers = 0;
        repeat (10) step();
        check("midrst_no_words", xfers, 32'd0);
        check("midrst_busy_after", {31'd0, busy}, 32'd0);

        // Enable gating after the third read
        do_reset(8, 16'h0300, 1'b1, 1'b1);
        for (int i = 0; i < 30 && reads < 3; i++) step();
        enable = 1'b0;
        repeat (20) step();
        check("gate_reads", reads, 32'd3);
        check("gate_xfers", xfers, 32'd3);
        check("gate_word_count", word_count, 32'd3);
        check("gate_busy", {31'd0, busy}, 32'd0);

        // Push/pop together with pointer wrap, m_ready toggling
        do_reset(12, 16'h0400, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            m_ready = i[0];
            step();
        end
        m_ready = 1'b1;
        repeat (10) step();
        check("wrap_xfers", xfers, 32'd12);
        check("wrap_word_count", word_count, 32'd12);
        check("wrap_all_out", exp_q.size(), 32'd0);
        check("wrap_max_outstanding", {31'd0, max_out <= 4}, 32'd1);
        check("wrap_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
